// File: rtl/program_loader.sv
// Streams a 16-byte image into the RAM programming port, zero-fills the tail, then reads back and checksums it.
// Latency: 33 cycles start->done plus one per in_valid stall; backpressure: in_ready is high in LOAD only, independent of in_valid.
module program_loader (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       ram_manual_mode,
    output logic       ram_manual_read,
    output logic [3:0] ram_address,
    output logic [7:0] ram_program_switches,
    input  logic [7:0] ram_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_VERIFY
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] ptr_q, ptr_d;
    logic [7:0] wsum_q, wsum_d;
    logic [7:0] rsum_q, rsum_d;
    logic       done_q, done_d;
    logic       error_q, error_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 4'd0;
            wsum_q  <= 8'd0;
            rsum_q  <= 8'd0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wsum_q  <= wsum_d;
            rsum_q  <= rsum_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        ptr_d                = ptr_q;
        wsum_d               = wsum_q;
        rsum_d               = rsum_q;
        done_d               = 1'b0;
        error_d              = error_q;
        in_ready             = 1'b0;
        ram_manual_read      = 1'b0;
        ram_address          = 4'd0;
        ram_program_switches = 8'd0;
        busy                 = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                // The done cycle is already IDLE, but a start there must wait one more cycle.
                if (start && !done_q) begin
                    ptr_d   = 4'd0;
                    wsum_d  = 8'd0;
                    rsum_d  = 8'd0;
                    error_d = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                in_ready    = 1'b1;
                ram_address = ptr_q;
                if (in_valid) begin
                    ram_manual_read      = 1'b1;
                    ram_program_switches = in_data;
                    wsum_d               = wsum_q + in_data;
                    if (ptr_q == 4'd15) begin
                        ptr_d   = 4'd0;
                        state_d = S_VERIFY;
                    end else begin
                        ptr_d = ptr_q + 4'd1;
                        if (in_last) begin
                            state_d = S_FILL;
                        end
                    end
                end
            end
            S_FILL: begin
                ram_manual_read = 1'b1;
                ram_address     = ptr_q;
                if (ptr_q == 4'd15) begin
                    ptr_d   = 4'd0;
                    state_d = S_VERIFY;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            S_VERIFY: begin
                ram_address = ptr_q;
                rsum_d      = rsum_q + ram_data;
                if (ptr_q == 4'd15) begin
                    error_d = error_q | (rsum_d != wsum_q);
                    done_d  = 1'b1;
                    ptr_d   = 4'd0;
                    state_d = S_IDLE;
                end else begin
                    ptr_d = ptr_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ram_manual_mode = busy;
    assign done            = done_q;
    assign error           = error_q;

endmodule

// File: doc/program_loader.md
# program_loader

Sequencer that writes a 16-byte program image into the 16x8 RAM through the RAM's manual-programming port, replacing hand entry on the program switches. It accepts bytes over a valid/ready stream, writes them to consecutive addresses starting at 0, and zero-fills the rest if the stream ends early. It then reads all 16 locations back, compares an 8-bit checksum, and reports done/error. It sits between a byte source (host link or test ROM) and the RAM, and holds the RAM in manual mode while it runs.

## Interface
No parameters. RAM depth is fixed at 16 and data width at 8.
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin load; sampled only in IDLE
- in_valid  in  1  in_data holds a byte
- in_data  in  8  program byte
- in_last  in  1  qualifies in_valid; marks the final byte of the image
- in_ready  out  1  loader accepts a byte this cycle
- ram_manual_mode  out  1  drives the RAM manual-mode select
- ram_manual_read  out  1  RAM write strobe; the RAM latches ram_program_switches on posedge
- ram_address  out  4  RAM address
- ram_program_switches  out  8  byte to be written
- ram_data  in  8  RAM combinational read data (RAM bus_out)
- busy  out  1  high in LOAD, FILL and VERIFY
- done  out  1  one-cycle pulse when the sequence completes
- error  out  1  checksum mismatch; sticky until next accepted start

## Operation
- States: IDLE, LOAD, FILL, VERIFY. Registers: ptr[3:0], wsum[7:0], rsum[7:0], state, done, error.
- IDLE:
  - in_ready=0, strobe=0.
  - When start=1: clear ptr, wsum and rsum; clear error; go to LOAD.
  - start is ignored in every other state.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: strobe=1 (combinational), ram_address=ptr, ram_program_switches=in_data. Then wsum+=in_data (mod 256).
  - After the handshake:
    - If ptr==15: go to VERIFY, ptr<=0.
    - Else if in_last: go to FILL, ptr<=ptr+1.
    - Else: ptr<=ptr+1, stay in LOAD.
  - in_last at ptr==15 behaves the same as a normal ptr==15 byte.
  - With no handshake, all registers hold.
- FILL:
  - in_ready=0, strobe=1 every cycle, ram_program_switches=0, ram_address=ptr.
  - At ptr==15: go to VERIFY, ptr<=0. Otherwise ptr++.
  - wsum is unchanged, since zeros add nothing.
- VERIFY:
  - strobe=0, ram_address=ptr. Each cycle rsum+=ram_data.
  - At ptr==15: compare (rsum+ram_data) mod 256 against wsum.
  - Set error=1 on mismatch. Pulse done. Go to IDLE.
- ram_manual_mode=busy, driven combinationally from state.
- In IDLE, ram_address=0 and ram_program_switches=0.
- Reset (asynchronous, any state): state=IDLE, ptr/wsum/rsum=0, done=0, error=0.
  - All outputs return to 0 immediately, including ram_manual_mode and strobe.
  - Partially written RAM contents are left as-is.

## Timing
- Count cycles from the cycle in which start is sampled high in IDLE (cycle 0).
- LOAD begins in cycle 1. Each accepted byte costs one cycle, and the write commits at the end of that cycle.
- FILL writes one address per cycle. VERIFY reads one address per cycle.
- Full 16-byte image with in_valid held high:
  - Writes occur in cycles 1–16.
  - VERIFY runs in cycles 17–32.
  - done=1 and busy=0 in cycle 33.
- Image of N bytes (1≤N≤16) with no stalls: done arrives in cycle 33. Total latency is 16 writes + 16 reads + 1, independent of N.
- Each in_valid stall cycle adds one cycle.
- in_ready is a function of state only. It does not depend on in_valid.
- error is valid from the done cycle onward and holds until the next accepted start.
- If start is high in the done cycle, it is not sampled, because state is IDLE only from cycle 33's edge. start is sampled in the next cycle.

## Test plan
- Reset, then load bytes 0x01..0x10 with in_last on the 16th byte:
  - The RAM model holds mem[i]=i+1.
  - wsum=0x88.
  - done in cycle 33, error=0.
  - ram_manual_mode high exactly in cycles 1–32.
- Load 3 bytes {0xAA,0x55,0x0F} with in_last on byte 3:
  - mem[0..2] match the bytes, mem[3..15]=0.
  - Addresses 3–15 are written in FILL during cycles 4–16.
  - done in cycle 33, error=0.
- Full load with in_valid low every other cycle:
  - in_ready stays 1 and no write strobe occurs in the idle cycles.
  - done is delayed by exactly the number of stall cycles.
- The RAM model corrupts mem[7] (XOR 0x01) after the writes:
  - done pulse with error=1.
  - The next start clears error in cycle 1.
  - A clean reload then ends with error=0.
- Assert rst asynchronously mid-LOAD (ptr=5):
  - ram_manual_mode, in_ready, busy and strobe drop before the next edge.
  - After rst deasserts, no activity occurs until start. start is ignored while busy.
